sequence_az: RTL and testbench
==============================

SEQUENCE_AZ -- requirements
Module: sequence_az

Interface
REQ-001 SHALL have parameter AZMUX_WIDTH, default 4, width of azmux control bus.
REQ-002 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port run  input  1  level; 1 = sequence active, 0 = return to IDLE.
REQ-005 SHALL have port clk_settle_duration  input  24  settle cycles after each azmux switch, sampled at each phase start.
REQ-006 SHALL have port azmux_lo_val  input  AZMUX_WIDTH  azmux code for zero (LO) phase.
REQ-007 SHALL have port azmux_hi_val  input  AZMUX_WIDTH  azmux code for signal (HI) phase.
REQ-008 SHALL have port adc_measure_valid  input  1  from adc; rises when measurement complete.
REQ-009 SHALL have port azmux  output  AZMUX_WIDTH  registered mux control.
REQ-010 SHALL have port adc_measure_trig  output  1  registered one-cycle start pulse to adc.
REQ-011 SHALL have port phase_hi  output  1  registered; 1 = current phase HI, 0 = LO.
REQ-012 SHALL have port sample_valid  output  1  one-cycle pulse, HI/LO pair complete.
REQ-013 SHALL have port sample_count  output  16  completed pair count.
REQ-014 SHALL have port monitor  output  6  [0]=adc_measure_trig, [1]=adc_measure_valid, [2]=phase_hi, [3]=sample_valid, [5:4]=state code.

Function
REQ-015 SHALL implement states IDLE=0, SETTLE=1, TRIG=2, WAIT=3 (2-bit code on monitor[5:4]).
REQ-016 SHALL register adc_measure_valid into valid_prev each cycle; valid rise = valid & ~valid_prev.
REQ-017 IDLE, run=1: azmux<=azmux_lo_val, phase_hi<=0, count<=clk_settle_duration, -> SETTLE next cycle.
REQ-018 IDLE, run=0: azmux<=azmux_lo_val, trig 0, remain IDLE.
REQ-019 SETTLE: count decrements by 1 per cycle; when count==0 -> TRIG; duration 0 gives exactly one SETTLE cycle.
REQ-020 TRIG: adc_measure_trig<=1 for exactly one cycle, -> WAIT; trig SHALL be 0 in every other state.
REQ-021 WAIT: valid rises before TRIG ignored; first valid rise observed in WAIT ends the phase; valid held high from prior measurement SHALL NOT count (edge only).
REQ-022 On phase end with phase_hi=0: phase_hi<=1, azmux<=azmux_hi_val, count reload, -> SETTLE.
REQ-023 On phase end with phase_hi=1: phase_hi<=0, azmux<=azmux_lo_val, count reload, sample_valid<=1 one cycle, sample_count+1, -> SETTLE.
REQ-024 sample_count SHALL wrap 0xFFFF -> 0x0000 without flag.
REQ-025 run=0 in any non-IDLE state SHALL force IDLE next cycle, azmux<=azmux_lo_val, trig 0, phase_hi 0; partial pair not counted; sample_count held.
REQ-026 run falling in same cycle as valid rise: run wins, no sample_valid, no count increment.
REQ-027 azmux_lo_val/azmux_hi_val changes SHALL take effect only at next phase switch.
REQ-028 Latency run rise -> first trig = clk_settle_duration + 2 cycles.

Reset
REQ-029 reset_n=0 SHALL asynchronously set state IDLE, azmux=0, adc_measure_trig=0, phase_hi=0, sample_valid=0, sample_count=0, count=0, valid_prev=0.
REQ-030 After reset release, first active clk edge SHALL behave per IDLE rules; reset mid-WAIT SHALL discard pending measurement.

Verification
REQ-031 settle=5, lo=4'h1, hi=4'h2, adc mock valid 10 cycles after trig, run=1 -> azmux 0x1, trig at cycle 7, azmux 0x2 after valid, second trig 7 cycles later.
REQ-032 Same setup, 3 full pairs -> 3 sample_valid pulses, each 1 cycle, sample_count=3.
REQ-033 settle=0 -> trig 2 cycles after run rise; one SETTLE cycle per phase.
REQ-034 run dropped in WAIT of HI phase, valid rises same cycle -> IDLE, azmux=lo_val, no sample_valid, count unchanged.
REQ-035 sample_count preloaded by running 65535 pairs (or forced), one more pair -> sample_count=0.
REQ-036 reset_n pulsed low asynchronously mid-SETTLE -> all outputs zero immediately without clock edge; restart from IDLE.

Source files
------------

// File: rtl/sequence_az.sv
// Auto-zero sequencer. It alternates azmux between the LO and HI codes, waits for the input
// to settle, triggers the ADC, and counts each completed LO/HI measurement pair.
module sequence_az #(
    parameter int AZMUX_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   run,
    input  logic [23:0]            clk_settle_duration,
    input  logic [AZMUX_WIDTH-1:0] azmux_lo_val,
    input  logic [AZMUX_WIDTH-1:0] azmux_hi_val,
    input  logic                   adc_measure_valid,
    output logic [AZMUX_WIDTH-1:0] azmux,
    output logic                   adc_measure_trig,
    output logic                   phase_hi,
    output logic                   sample_valid,
    output logic [15:0]            sample_count,
    output logic [5:0]             monitor
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETTLE = 2'd1;
    localparam logic [1:0] ST_TRIG   = 2'd2;
    localparam logic [1:0] ST_WAIT   = 2'd3;

    logic [1:0]             state_q, state_d;
    logic [AZMUX_WIDTH-1:0] azmux_q, azmux_d;
    logic                   trig_q, trig_d;
    logic                   phase_hi_q, phase_hi_d;
    logic                   sample_valid_q, sample_valid_d;
    logic [15:0]            sample_count_q, sample_count_d;
    logic [23:0]            count_q, count_d;
    logic                   valid_prev_q;
    logic                   valid_rise;

    // Only a fresh edge ends a phase; a level left high by an earlier conversion is ignored.
    assign valid_rise = adc_measure_valid & ~valid_prev_q;

    always_comb begin
        state_d        = state_q;
        azmux_d        = azmux_q;
        trig_d         = 1'b0;
        phase_hi_d     = phase_hi_q;
        sample_valid_d = 1'b0;
        sample_count_d = sample_count_q;
        count_d        = count_q;

        if (!run) begin
            // Dropping run abandons any partial pair; the pair counter is left untouched.
            state_d    = ST_IDLE;
            azmux_d    = azmux_lo_val;
            phase_hi_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    azmux_d    = azmux_lo_val;
                    phase_hi_d = 1'b0;
                    count_d    = clk_settle_duration;
                    state_d    = ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (count_q == 24'd0) begin
                        state_d = ST_TRIG;
                    end else begin
                        count_d = count_q - 24'd1;
                    end
                end
                ST_TRIG: begin
                    trig_d  = 1'b1;
                    state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    if (valid_rise) begin
                        count_d = clk_settle_duration;
                        state_d = ST_SETTLE;
                        if (phase_hi_q) begin
                            phase_hi_d     = 1'b0;
                            azmux_d        = azmux_lo_val;
                            sample_valid_d = 1'b1;
                            sample_count_d = sample_count_q + 16'd1;
                        end else begin
                            phase_hi_d = 1'b1;
                            azmux_d    = azmux_hi_val;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    azmux_d = azmux_lo_val;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            azmux_q        <= '0;
            trig_q         <= 1'b0;
            phase_hi_q     <= 1'b0;
            sample_valid_q <= 1'b0;
            sample_count_q <= 16'd0;
            count_q        <= 24'd0;
            valid_prev_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            azmux_q        <= azmux_d;
            trig_q         <= trig_d;
            phase_hi_q     <= phase_hi_d;
            sample_valid_q <= sample_valid_d;
            sample_count_q <= sample_count_d;
            count_q        <= count_d;
            valid_prev_q   <= adc_measure_valid;
        end
    end

    assign azmux            = azmux_q;
    assign adc_measure_trig = trig_q;
    assign phase_hi         = phase_hi_q;
    assign sample_valid     = sample_valid_q;
    assign sample_count     = sample_count_q;
    assign monitor          = {state_q, sample_valid_q, phase_hi_q, adc_measure_valid, trig_q};

endmodule

// File: tb/tb_sequence_az.sv
// Bench for sequence_az: per-edge input schedules are planned ahead, and the trig and
// sample_valid events they imply are queued and matched by an independent monitor.
module tb_sequence_az;
  localparam int MAXC = 20000;
  localparam int REG  = 400;
  localparam int W    = 44;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        run = 1'b0;
  logic [23:0] settle = 24'd0;
  logic [3:0]  lo_val = 4'd0;
  logic [3:0]  hi_val = 4'd0;
  logic        adc_valid = 1'b0;
  logic [3:0]  azmux;
  logic        trig;
  logic        phase_hi;
  logic        sample_valid;
  logic [15:0] sample_count;
  logic [5:0]  monitor;

  sequence_az #(.AZMUX_WIDTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .run(run), .clk_settle_duration(settle),
    .azmux_lo_val(lo_val), .azmux_hi_val(hi_val), .adc_measure_valid(adc_valid),
    .azmux(azmux), .adc_measure_trig(trig), .phase_hi(phase_hi),
    .sample_valid(sample_valid), .sample_count(sample_count), .monitor(monitor)
  );

  // clock / reset / edge counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // per-edge input schedules: entry k is the value sampled at edge k
  logic        vmap[MAXC];
  logic        run_map[MAXC];
  logic [3:0]  lo_map[MAXC];
  logic [3:0]  hi_map[MAXC];
  logic [23:0] st_map[MAXC];

  always @(posedge clk) begin
    #1;
    if (cyc + 1 < MAXC) begin
      run       = run_map[cyc + 1];
      adc_valid = vmap[cyc + 1];
      lo_val    = lo_map[cyc + 1];
      hi_val    = hi_map[cyc + 1];
      settle    = st_map[cyc + 1];
    end
  end

  // scoreboard
  logic [W-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;
  logic [15:0] model_cnt = 16'd0;

  function automatic logic [W-1:0] pack_ev(input logic kind, input int ed, input logic [1:0] st,
                                            input logic [3:0] az, input logic ph, input logic [15:0] cnt);
    logic [19:0] e20;
    e20 = ed[19:0];
    return {kind, e20, st, az, ph, cnt};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic check_event(input string nm, input logic [W-1:0] act);
    logic [W-1:0] exp;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: unexpected event %h at edge %0d, expected none", nm, act, cyc);
    end else begin
      exp = exp_q.pop_front();
      if (act !== exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h (edge %0d)", nm, act, exp, cyc);
      end
    end
  endtask

  // monitor
  always @(negedge clk) begin
    if (reset_n) begin
      if (trig)
        check_event("trig", pack_ev(1'b0, cyc, monitor[5:4], azmux, phase_hi, 16'd0));
      if (sample_valid)
        check_event("sample_valid", pack_ev(1'b1, cyc, monitor[5:4], azmux, phase_hi, sample_count));
      chk("monitor_valid_bit", {31'd0, monitor[1]}, {31'd0, adc_valid});
    end
  end

  // Plan one run episode starting at edge r. mode: 0 clean stop, 1 drop on a HI valid rise,
  // 2 random drop, 3 drop mid-settle (reset test). dir: 0 random, 1 settle=5/lo=1/hi=2/d=10,
  // 2 settle=0.
  task automatic plan_episode(input int r, input int mode, input int dir, input int nph, output int x);
    logic [3:0]  lo_a, hi_a, lo_b, hi_b;
    logic [23:0] s_a, s_b;
    int cp, p, t, rr, h, s_next, e_last;
    logic ph;
    int ev_ed[$];
    logic ev_kind[$];
    logic [3:0] ev_az[$];
    logic ev_ph[$];
    int hi_rise[$];
    lo_a = 4'($urandom); hi_a = 4'($urandom); lo_b = 4'($urandom); hi_b = 4'($urandom);
    s_a = 24'($urandom_range(0, 6)); s_b = 24'($urandom_range(0, 6));
    cp = r + $urandom_range(0, 50);
    if (dir == 1) begin
      lo_a = 4'h1; hi_a = 4'h2; s_a = 24'd5; cp = r + REG;
    end else if (dir == 2) begin
      s_a = 24'd0; s_b = 24'd0;
    end
    if (mode == 3) begin
      s_a = 24'd8; lo_a = lo_a | 4'h1; cp = r + REG;
    end
    for (int k = r; k < r + REG; k++) begin
      lo_map[k] = (k < cp) ? lo_a : lo_b;
      hi_map[k] = (k < cp) ? hi_a : hi_b;
      st_map[k] = (k < cp) ? s_a : s_b;
      vmap[k] = 1'b0;
      run_map[k] = 1'b0;
    end
    p = r; ph = 1'b0; e_last = r;
    for (int i = 0; i < nph + 2; i++) begin
      t = p + int'(st_map[p]) + 2;
      ev_kind.push_back(1'b0); ev_ed.push_back(t);
      ev_az.push_back(ph ? hi_map[p] : lo_map[p]); ev_ph.push_back(ph);
      if (dir == 0 && $urandom_range(0, 3) == 0) begin
        // valid already high when the trigger fires: only the later edge may end the phase
        for (int k = t - 1; k <= t + 2; k++) vmap[k] = 1'b1;
        rr = t + 4 + $urandom_range(0, 3);
        for (int k = t + 3; k < rr; k++) vmap[k] = 1'b0;
      end else begin
        rr = (dir == 1) ? t + 10 : t + $urandom_range(1, 6);
        for (int k = t; k < rr; k++) vmap[k] = 1'b0;
      end
      s_next = int'(st_map[rr]);
      h = (dir == 1) ? 1 : $urandom_range(1, s_next + 1);
      for (int k = rr; k < rr + h; k++) vmap[k] = 1'b1;
      if (ph) begin
        ev_kind.push_back(1'b1); ev_ed.push_back(rr); ev_az.push_back(lo_map[rr]); ev_ph.push_back(1'b0);
        hi_rise.push_back(rr);
      end
      if (i == nph - 1) e_last = rr;
      p = rr; ph = ~ph;
    end
    case (mode)
      0: x = e_last + $urandom_range(1, 3);
      1: x = hi_rise[$urandom_range(0, hi_rise.size() - 1)];
      2: x = $urandom_range(r + 1, e_last);
      default: x = r + 3;
    endcase
    for (int k = r; k < x; k++) run_map[k] = 1'b1;
    for (int k = x + 1; k < r + REG; k++) vmap[k] = 1'b0;
    for (int j = 0; j < ev_ed.size(); j++) begin
      if (ev_ed[j] < x) begin
        if (ev_kind[j]) begin
          model_cnt = model_cnt + 16'd1;
          exp_q.push_back(pack_ev(1'b1, ev_ed[j], 2'd1, ev_az[j], 1'b0, model_cnt));
        end else begin
          exp_q.push_back(pack_ev(1'b0, ev_ed[j], 2'd3, ev_az[j], ev_ph[j], 16'd0));
        end
      end
    end
  endtask

  task automatic end_checks(input int x);
    while (cyc < x) @(negedge clk);
    #1;
    chk("idle_state", {30'd0, monitor[5:4]}, 32'd0);
    chk("idle_azmux", {28'd0, azmux}, {28'd0, lo_map[x]});
    chk("idle_phase_hi", {31'd0, phase_hi}, 32'd0);
    chk("idle_trig", {31'd0, trig}, 32'd0);
    chk("idle_sample_valid", {31'd0, sample_valid}, 32'd0);
    chk("held_count", {16'd0, sample_count}, {16'd0, model_cnt});
    chk("pending_events", exp_q.size(), 32'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
  endtask

  task automatic episode(input int mode, input int dir, input int nph);
    int x;
    plan_episode(cyc + 2, mode, dir, nph, x);
    end_checks(x);
  endtask

  initial begin
    int x, r;
    for (int k = 0; k < MAXC; k++) begin
      vmap[k] = 1'b0; run_map[k] = 1'b0; lo_map[k] = 4'd0; hi_map[k] = 4'd0; st_map[k] = 24'd0;
    end
    repeat (3) @(negedge clk);
    chk("reset_azmux", {28'd0, azmux}, 32'd0);
    chk("reset_trig", {31'd0, trig}, 32'd0);
    chk("reset_phase_hi", {31'd0, phase_hi}, 32'd0);
    chk("reset_sample_valid", {31'd0, sample_valid}, 32'd0);
    chk("reset_count", {16'd0, sample_count}, 32'd0);
    chk("reset_monitor", {26'd0, monitor}, 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    episode(0, 1, 3);
    episode(0, 2, 4);
    episode(1, 0, 4);
    episode(2, 0, 5);
    for (int i = 0; i < 16; i++) episode($urandom_range(0, 2), 0, $urandom_range(2, 8));

    // counter wrap: preload near the top while idle, then complete pairs past 0xFFFF
    force dut.sample_count_q = 16'hFFFE;
    @(posedge clk);
    #1;
    release dut.sample_count_q;
    model_cnt = 16'hFFFE;
    @(negedge clk);
    chk("preload_count", {16'd0, sample_count}, 32'h0000FFFE);
    episode(0, 0, 6);

    // asynchronous reset in the middle of SETTLE
    r = cyc + 2;
    plan_episode(r, 3, 0, 2, x);
    while (cyc < r + 2) @(negedge clk);
    chk("pre_reset_settle", {30'd0, monitor[5:4]}, 32'd1);
    chk("pre_reset_azmux", {28'd0, azmux}, {28'd0, lo_map[r]});
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset_azmux", {28'd0, azmux}, 32'd0);
    chk("async_reset_state", {30'd0, monitor[5:4]}, 32'd0);
    chk("async_reset_count", {16'd0, sample_count}, 32'd0);
    chk("async_reset_flags", {29'd0, trig, phase_hi, sample_valid}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    model_cnt = 16'd0;
    chk("reset_pending_events", exp_q.size(), 32'd0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    chk("post_reset_state", {30'd0, monitor[5:4]}, 32'd0);
    episode(0, 0, 4);
    episode(1, 2, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #(MAXC * 10 - 100);
    $display("FAIL watchdog: simulation time limit reached at edge %0d", cyc);
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end
endmodule
